// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM state type, halt encoding and default widths.
package cpu_pkg;

  localparam int unsigned LUT_KEY_W    = 5;
  localparam int unsigned PC_W_DEFAULT = 10;
  localparam logic [8:0]  HALT_INST    = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit control/instruction bus; slave is the fetch unit, master drives it.
interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
);
  logic                 start;
  logic                 stall;
  logic [8:0]           inst;
  logic                 branch_en;
  logic                 lut_we;
  logic [LUT_KEY_W-1:0] lut_addr;
  logic [PC_W-1:0]      lut_data;
  logic [PC_W-1:0]      pc;
  logic                 running;
  logic                 done;
  logic [15:0]          instr_count;

  modport slave (
    input  start, stall, inst, branch_en, lut_we, lut_addr, lut_data,
    output pc, running, done, instr_count
  );

  modport master (
    output start, stall, inst, branch_en, lut_we, lut_addr, lut_data,
    input  pc, running, done, instr_count
  );
endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target register file: async clear, synchronous write, combinational read.
module branch_lut #(
  parameter int unsigned W     = 10,
  parameter int unsigned KEY_W = 5,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [KEY_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [KEY_W-1:0] raddr,
  output logic [W-1:0]     rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC sequencing (IDLE/RUN/HALT) with branch-target table.
// Optional retired-instruction counter enabled by `define FETCH_INSTR_COUNT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W      = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] START_PC  = '0,
  parameter int unsigned     LUT_DEPTH = 2**LUT_KEY_W
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.slave  bus
);
  fetch_state_t    state, state_nx;
  logic [PC_W-1:0] pc_q, pc_nx;
  logic [PC_W-1:0] lut_rd;
  logic            lut_wr;

  branch_lut #(
    .W     (PC_W),
    .KEY_W (LUT_KEY_W),
    .DEPTH (LUT_DEPTH)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lut_wr),
    .waddr (bus.lut_addr),
    .wdata (bus.lut_data),
    .raddr (bus.inst[LUT_KEY_W-1:0]),
    .rdata (lut_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_q  <= START_PC;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    lut_wr   = 1'b0;
    unique case (state)
      RUN: begin
        // Halt encoding outranks both stall and branch.
        if (bus.inst == HALT_INST) begin
          state_nx = HALT;
        end else if (!bus.stall) begin
          pc_nx = bus.branch_en ? lut_rd : pc_q + PC_W'(1);
        end
      end
      default: begin
        lut_wr = bus.lut_we;
        if (bus.start) begin
          state_nx = RUN;
          pc_nx    = START_PC;
        end
      end
    endcase
  end

  assign bus.pc      = pc_q;
  assign bus.running = (state == RUN);
  assign bus.done    = (state == HALT);

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] count;
  logic        retire, accept;

  assign retire = (state == RUN) && (bus.inst != HALT_INST) && !bus.stall;
  assign accept = (state != RUN) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        count <= '0;
    else if (accept)                   count <= '0;
    else if (retire && count != '1)    count <= count + 16'd1;
  end

  assign bus.instr_count = count;
`else
  assign bus.instr_count = '0;
`endif
endmodule
